// File: rtl/array_max_scanner_if.sv
// Port bundle between the MIPS datapath (master) and the array max scanner (slave).
// Handshake: master raises start with len while busy=0; the scanner accepts it on that edge and pulses done once.
interface array_max_scanner_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      memRdData;
    logic [31:0]      memAdr;
    logic [31:0]      memWrData;
    logic             memRead;
    logic             memWrite;
    logic             busy;
    logic             done;
    logic [31:0]      maxValue;
    logic [31:0]      maxIndex;

    modport master (
        output start, len, memRdData,
        input  memAdr, memWrData, memRead, memWrite, busy, done, maxValue, maxIndex
    );

    modport slave (
        input  start, len, memRdData,
        output memAdr, memWrData, memRead, memWrite, busy, done, maxValue, maxIndex
    );
endinterface

// File: rtl/array_max_scanner.sv
// Scans len words from BASE_ADR for the maximum and writes value/index to MAX_ADR/IDX_ADR.
// Define ARRAY_MAX_UNSIGNED_EN to compare elements as unsigned instead of signed.
module array_max_scanner #(
    parameter logic [31:0] BASE_ADR = 32'd1000,
    parameter logic [31:0] MAX_ADR  = 32'd2000,
    parameter logic [31:0] IDX_ADR  = 32'd2004,
    parameter int          LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    array_max_scanner_if.slave  bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WR_MAX = 3'd2,
        WR_IDX = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] i;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [31:0]      max_q;
    logic [31:0]      max_value;
    logic [31:0]      max_index;
    logic             last;
    logic             greater;

    assign last = (i == len_q - LEN_W'(1));

`ifdef ARRAY_MAX_UNSIGNED_EN
    assign greater = bus.memRdData > max_q;
`else
    assign greater = $signed(bus.memRdData) > $signed(max_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.memAdr    = 32'd0;
        bus.memWrData = 32'd0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_next = (bus.len == '0) ? DONE : READ;
            end
            READ: begin
                bus.memRead = 1'b1;
                bus.memAdr  = BASE_ADR + (32'(i) << 2);
                if (last) state_next = WR_MAX;
            end
            WR_MAX: begin
                bus.memWrite  = 1'b1;
                bus.memAdr    = MAX_ADR;
                bus.memWrData = max_q;
                state_next    = WR_IDX;
            end
            WR_IDX: begin
                bus.memWrite  = 1'b1;
                bus.memAdr    = IDX_ADR;
                bus.memWrData = 32'(idx_q);
                state_next    = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Element 0 seeds the running max; later elements replace it only when strictly greater.
    always_ff @(posedge clk) begin
        if (rst) begin
            i         <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            max_value <= '0;
            max_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i     <= '0;
                        len_q <= bus.len;
                        idx_q <= '0;
                        max_q <= '0;
                        if (bus.len == '0) begin
                            max_value <= '0;
                            max_index <= '0;
                        end
                    end
                end
                READ: begin
                    if (i == '0 || greater) begin
                        max_q <= bus.memRdData;
                        idx_q <= i;
                    end
                    if (!last) i <= i + LEN_W'(1);
                end
                WR_IDX: begin
                    max_value <= max_q;
                    max_index <= 32'(idx_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.maxValue = max_value;
    assign bus.maxIndex = max_index;
    assign dbg_state    = state;

endmodule

// File: doc/array_max_scanner.md
Name: array_max_scanner

Overview:
- Sequential accelerator on the data-memory port of the single-cycle MIPS datapath, directly upstream of the data memory.
- On start it walks an array of 32-bit words from BASE_ADR and finds the largest element and its index.
- It writes the result to the memory words at MAX_ADR (2000) and IDX_ADR (2004), where the data memory exposes them as maxValue/maxIndex.
- Memory read is combinational (asynchronous); memory write takes effect at posedge clk.

Parameters:
- BASE_ADR, 1000, byte address of element 0 (word 250).
- MAX_ADR, 2000, byte address where the maximum value is written (word 500).
- IDX_ADR, 2004, byte address where the index of the maximum is written (word 501).
- LEN_W, 16, width of the len input.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  begin scan; sampled only in IDLE
- len  input  LEN_W  number of elements; sampled with start
- memRdData  input  32  data-memory outputData (combinational read)
- memAdr  output  32  byte address to data memory
- memWrData  output  32  data to data memory inputData
- memRead  output  1  data-memory MemRead
- memWrite  output  1  data-memory MemWrite
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a scan completes
- maxValue  output  32  registered maximum of the last completed scan
- maxIndex  output  32  registered 0-based index of that maximum

Behaviour:
- Reset: synchronous active-high; rst=1 at posedge forces state IDLE.
- Values after reset: i=0, busy=0, done=0, memRead=0, memWrite=0, memAdr=0, memWrData=0, maxValue=0, maxIndex=0.
- Reset mid-scan: abort immediately; no further memory writes; results from the aborted scan are discarded.
- States: IDLE, READ, WR_MAX, WR_IDX, DONE.
- IDLE:
  - start=1 and len!=0: latch len, i=0, go to READ.
  - start=1 and len==0: go to DONE with maxValue=0, maxIndex=0, no memory access.
  - start is ignored whenever busy=1.
- READ:
  - memRead=1; memAdr=BASE_ADR+4*i (32-bit, wraps mod 2^32); memRdData sampled at posedge.
  - i==0: load max=memRdData, idx=0 unconditionally.
  - i>0: update only if memRdData > max, strictly greater and signed (two's complement), so ties keep the earliest index.
  - i==len-1: go to WR_MAX; otherwise i=i+1.
- WR_MAX: memWrite=1, memRead=0, memAdr=MAX_ADR, memWrData=max.
- WR_IDX: memWrite=1, memAdr=IDX_ADR, memWrData={zero-extend idx}.
- DONE:
  - done=1 for exactly one cycle; maxValue/maxIndex update on entry to DONE and hold until the next completed scan.
  - Next state IDLE.
- Outside READ/WR_*: memRead=0, memWrite=0 (the datapath mux owns the port when busy=0).
- Latency, start sampled at edge 0: reads occupy cycles 1..len; writes at len+1 and len+2; done high in cycle len+3. Total len+3 cycles; back-to-back start accepted the cycle after DONE.
- len counter is LEN_W bits; len=2^LEN_W-1 is legal, and i never exceeds len-1.

Optional Feature:
- Macro: ARRAY_MAX_UNSIGNED_EN.
- Defined: READ comparison is unsigned (e.g. 0xFFFFFFFF beats 0x00000001).
- Undefined (default): signed comparison (0xFFFFFFFF = -1 loses to 1).
- All else identical.

Test Plan:
- Values after reset: rst high 2 cycles -> busy=0, done=0, memWrite=0, maxValue=0, maxIndex=0.
- Basic scan:
  - Stimulus: words 250..254 = {3, 9, -4, 7, 2}, start with len=5.
  - Response: memWrite at cycles 6 and 7 writes 9 to adr 2000 and 1 to adr 2004; done in cycle 8; maxValue=9, maxIndex=1.
- Tie and signed compare:
  - Stimulus: array {-5, 12, 12, 0xFFFFFFFF}, len=4.
  - Response without macro: max=12, idx=1. With ARRAY_MAX_UNSIGNED_EN: max=0xFFFFFFFF, idx=3.
- Edge lengths:
  - len=1, array {-100} -> max=-100, idx=0, done in cycle 4.
  - len=0 -> no memRead/memWrite, done in cycle 1, maxValue=0, maxIndex=0.
- Reset mid-scan and start while busy:
  - rst asserted in READ with i=2 of len=5 -> no write to 2000/2004 follows; outputs 0.
  - start pulsed while busy -> ignored; scan length unchanged.
- Back-to-back scans: start len=3 then start again the cycle after DONE with new data -> second result overwrites 2000/2004 and maxValue/maxIndex.
